// File: rtl/fetch_unit_pkg.sv
// Shared RV32I core definitions: XLEN, reset PC, NOP encoding,
// major opcodes and the IF/ID bundle carried from fetch to decode.
package fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_REG      = 7'b0110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } if_id_t;

   localparam if_id_t IF_ID_RESET = '{
      valid: 1'b0,
      instr: NOP_INSTR,
      pc:    '0
   };

   function automatic logic [XLEN-1:0] word_align(
      input logic [XLEN-1:0] a
   );
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetch response that arrives
// while decode is stalled; flush wins over load, load over drain.
module fetch_skid
   import fetch_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            load,
   input  logic            drain,
   input  logic [XLEN-1:0] load_instr,
   input  logic [XLEN-1:0] load_pc,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc    <= RESET_PC;
      end else begin
         if (flush) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
         end else if (drain) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID register: PC sequencing,
// 1-cycle imem reads, stall skid buffering and redirect flush.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rsp_pc_q;
   logic            rsp_pending;

   if_id_t          out_q;
   if_id_t          out_d;
   if_id_t          skid_q;

   logic            skid_valid;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] skid_pc;

   logic            hold;
   logic            adv;
   logic            issue;
   logic            skid_load;
   logic            sel_skid;
   logic            sel_rsp;
   logic            sel_bub;
   logic            unused_rpc_lsb;

   assign unused_rpc_lsb = ^redirect_pc[1:0];

   // A bubble under stall is not held; decode may overwrite it.
   assign hold  = id_stall & out_q.valid;
   assign adv   = ~redirect_valid & ~hold;

   // Never issue while a captured response could still need the skid.
   assign issue = ~redirect_valid
                & ~skid_valid
                & ~(rsp_pending & hold);

   assign imem_en   = issue & rst_n;
   assign imem_addr = pc_q;

   assign skid_load = ~redirect_valid & hold & rsp_pending;
   assign sel_skid  = adv & skid_valid;
   assign sel_rsp   = adv & ~skid_valid & rsp_pending;
   assign sel_bub   = adv & ~skid_valid & ~rsp_pending;

   assign skid_q.valid = skid_valid;
   assign skid_q.instr = skid_instr;
   assign skid_q.pc    = skid_pc;

   fetch_skid u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .load       (skid_load),
      .drain      (sel_skid),
      .load_instr (imem_rdata),
      .load_pc    (rsp_pc_q),
      .valid      (skid_valid),
      .instr      (skid_instr),
      .pc         (skid_pc)
   );

   always_comb begin
      out_d = out_q;
      unique case (1'b1)
         redirect_valid: begin
            out_d.valid = 1'b0;
            out_d.instr = NOP_INSTR;
         end
         sel_skid: begin
            out_d = skid_q;
         end
         sel_rsp: begin
            out_d.valid = 1'b1;
            out_d.instr = imem_rdata;
            out_d.pc    = rsp_pc_q;
         end
         sel_bub: begin
            out_d.valid = 1'b0;
            out_d.instr = NOP_INSTR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         rsp_pc_q    <= RESET_PC;
         rsp_pending <= 1'b0;
         out_q       <= IF_ID_RESET;
      end else begin
         out_q <= out_d;
         if (redirect_valid) begin
            pc_q        <= word_align(redirect_pc);
            rsp_pending <= 1'b0;
         end else begin
            rsp_pending <= issue;
            if (issue) begin
               pc_q     <= pc_q + PC_STEP;
               rsp_pc_q <= pc_q;
            end
         end
      end
   end

   assign if_valid = out_q.valid;
   assign if_instr = out_q.instr;
   assign if_pc    = out_q.pc;

   skid_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(skid_load && skid_valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit; a stream-level
// scoreboard tracks the expected next PC of the decode stream.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_pc = 32'h0;
   int          idle = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
   endfunction

   // Synchronous instruction memory, garbage when not enabled.
   always @(posedge clk)
      imem_rdata <= imem_en ? memword(imem_addr) : 32'hDEAD_BEEF;

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(
      input logic        st,
      input logic        rv,
      input logic [31:0] rp
   );
      @(posedge clk);
      #1;
      id_stall       = st;
      redirect_valid = rv;
      redirect_pc    = rp;
      @(negedge clk);
   endtask

   // Decode-side view: each accepted instruction is the next PC.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc = 32'h0;
         idle   = 0;
         check("rst_imem_en", 32'(imem_en), 32'd0);
      end else begin
         if (imem_en)
            check("addr_align", 32'(imem_addr[1:0]), 32'd0);
         if (if_valid) begin
            check("sb_pc", if_pc, exp_pc);
            check("sb_instr", if_instr, memword(if_pc));
         end else begin
            check("sb_nop", if_instr, 32'h0000_0013);
         end
         if (redirect_valid)
            exp_pc = {redirect_pc[31:2], 2'b00};
         else if (if_valid && !id_stall)
            exp_pc = exp_pc + 32'd4;
         if (if_valid || redirect_valid)
            idle = 0;
         else
            idle = idle + 1;
         check("sb_progress", 32'(idle > 6), 32'd0);
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_instr", if_instr, 32'h0000_0013);
      check("rst_pc", if_pc, 32'h0);

      // t0: first issue at the reset PC
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t0_en", 32'(imem_en), 32'd1);
      check("t0_addr", imem_addr, 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
      check("t1_addr", imem_addr, 32'h4);
      check("t1_valid", 32'(if_valid), 32'd0);
      cyc(1'b0, 1'b0, 32'h0);
      check("t2_valid", 32'(if_valid), 32'd1);
      check("t2_pc", if_pc, 32'h0);
      check("t2_instr", if_instr, memword(32'h0));
      cyc(1'b0, 1'b0, 32'h0);
      check("t3_pc", if_pc, 32'h4);

      // stall three cycles while if_pc = 8
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 32'h0);
         check("stall_pc", if_pc, 32'h8);
         check("stall_valid", 32'(if_valid), 32'd1);
         check("stall_en", 32'(imem_en), 32'd0);
      end
      cyc(1'b0, 1'b0, 32'h0);
      check("rel_pc", if_pc, 32'h8);
      check("rel_en", 32'(imem_en), 32'd0);
      cyc(1'b0, 1'b0, 32'h0);
      check("skid_pc", if_pc, 32'hC);
      check("skid_instr", if_instr, memword(32'hC));
      check("resume_en", 32'(imem_en), 32'd1);
      check("resume_addr", imem_addr, 32'h10);
      repeat (4) cyc(1'b0, 1'b0, 32'h0);

      // redirect with misaligned target
      cyc(1'b0, 1'b1, 32'h103);
      check("redir_en", 32'(imem_en), 32'd0);
      cyc(1'b0, 1'b0, 32'h0);
      check("redir1_valid", 32'(if_valid), 32'd0);
      check("redir1_addr", imem_addr, 32'h100);
      check("redir1_en", 32'(imem_en), 32'd1);
      cyc(1'b0, 1'b0, 32'h0);
      check("redir2_valid", 32'(if_valid), 32'd0);
      cyc(1'b0, 1'b0, 32'h0);
      check("redir3_valid", 32'(if_valid), 32'd1);
      check("redir3_pc", if_pc, 32'h100);
      repeat (2) cyc(1'b0, 1'b0, 32'h0);

      // fill skid, then redirect while stall stays high
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h203);
      check("sr_en", 32'(imem_en), 32'd0);
      cyc(1'b1, 1'b0, 32'h0);
      check("sr1_valid", 32'(if_valid), 32'd0);
      check("sr1_en", 32'(imem_en), 32'd1);
      check("sr1_addr", imem_addr, 32'h200);
      cyc(1'b1, 1'b0, 32'h0);
      check("sr2_valid", 32'(if_valid), 32'd0);
      cyc(1'b1, 1'b0, 32'h0);
      check("sr3_pc", if_pc, 32'h200);
      check("sr3_valid", 32'(if_valid), 32'd1);
      cyc(1'b1, 1'b0, 32'h0);
      check("sr4_pc", if_pc, 32'h200);
      repeat (5) cyc(1'b0, 1'b0, 32'h0);

      // PC wraps past the top of the address space
      cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
      repeat (3) cyc(1'b0, 1'b0, 32'h0);
      check("wrap0_pc", if_pc, 32'hFFFF_FFF8);
      check("wrap_addr", imem_addr, 32'h0);
      cyc(1'b0, 1'b0, 32'h0);
      check("wrap1_pc", if_pc, 32'hFFFF_FFFC);
      cyc(1'b0, 1'b0, 32'h0);
      check("wrap2_pc", if_pc, 32'h0);

      // randomized stall / redirect traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 99) < 30),
             ($urandom_range(0, 99) < 5),
             $urandom);
      end
      repeat (3) cyc(1'b0, 1'b0, 32'h0);

      // asynchronous reset mid-stall
      repeat (3) cyc(1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(if_valid), 32'd0);
      check("arst_instr", if_instr, 32'h0000_0013);
      check("arst_en", 32'(imem_en), 32'd0);
      check("arst_pc", if_pc, 32'h0);
      @(posedge clk);
      #1;
      id_stall = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("re_t0_en", 32'(imem_en), 32'd1);
      check("re_t0_addr", imem_addr, 32'h0);
      repeat (2) cyc(1'b0, 1'b0, 32'h0);
      check("re_t2_pc", if_pc, 32'h0);
      check("re_t2_valid", 32'(if_valid), 32'd1);
      repeat (4) cyc(1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
